// File: rtl/beta_pkg.sv
// beta_pkg: shared types and constants for the memory port arbiter.
package beta_pkg;

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} arb_state_t;
    typedef enum logic {OWN_I, OWN_D} arb_owner_t;

    localparam logic [31:0] ARB_ERR_RDATA = 32'h0;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: data-priority winner select with a fetch starvation guard.
module mem_arb_pick
    import beta_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_req,
    input  logic       d_req,
    input  logic       decide,
    output arb_owner_t owner
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          starved;

    // A data win with fetch pending implies the count is below the limit, so the increment saturates by construction.
    always_comb begin
        starved = i_req && (cnt_q == CW'(STARVE_LIMIT));
        owner   = (d_req && !starved) ? OWN_D : OWN_I;
        cnt_d   = cnt_q;
        if (decide)
            cnt_d = (owner == OWN_D && i_req) ? cnt_q + CW'(1) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory bus between fetch and data ports,
// one outstanding transaction at a time, with a read timeout that sets a sticky error.
module mem_port_arbiter
    import beta_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_valid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_gnt,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              bus_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q, owner_d, pick;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rd_val;
    logic              decide;

    assign decide = (state_q == IDLE) && (i_req || d_req);

    mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
        .clk    (clk),
        .rst    (rst),
        .i_req  (i_req),
        .d_req  (d_req),
        .decide (decide),
        .owner  (pick)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        tmo_d     = tmo_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        err_d     = err_q;
        rd_val    = m_rvalid ? m_rdata : DATA_W'(ARB_ERR_RDATA);
        case (state_q)
            IDLE: if (decide) begin
                state_d = REQ;
                owner_d = pick;
                we_d    = (pick == OWN_D) && d_we;
                addr_d  = (pick == OWN_D) ? d_addr : i_addr;
                wdata_d = (pick == OWN_D) ? d_wdata : '0;
            end
            REQ: if (m_gnt) begin
                state_d = we_q ? DONE : RESP;
                tmo_d   = '0;
            end
            // Real data wins over a timeout landing on the same cycle.
            RESP: if (m_rvalid || tmo_q == TW'(TIMEOUT - 1)) begin
                state_d = DONE;
                err_d   = err_q | !m_rvalid;
                if (owner_q == OWN_I)
                    i_rdata_d = rd_val;
                else
                    d_rdata_d = rd_val;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_I;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            tmo_q     <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            tmo_q     <= tmo_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            err_q     <= err_d;
        end
    end

    assign m_req   = (state_q == REQ);
    assign m_we    = we_q;
    assign m_addr  = addr_q;
    assign m_wdata = wdata_q;
    assign i_valid = (state_q == DONE) && (owner_q == OWN_I);
    assign d_valid = (state_q == DONE) && (owner_q == OWN_D);
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign bus_err = err_q;

endmodule
